keypad_emulator: RTL and testbench

Synthesizable model of the 3×4 matrix keypad: the device end of the row-strobe/column-sense interface that the keypad scanner drives. The scanner strobes one-hot `ROWS`. This block answers on `COLS` exactly as a physical keypad would, with a key held for a programmed duration and then released. Firmware or a testbench loads key codes through a simple load/busy handshake. It sits between the RAT port logic (or the bench) and the scanner's `ROWS`/`COLS` pins, so the scan path can be exercised without hardware.

---
 rtl/keypad_pkg.sv | 69 ++++++
 rtl/keypad_emulator.sv | 124 ++++++++++++
 tb/tb_keypad_emulator.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared 3x4 keypad definitions: FSM states, key codes, and the code <-> row/column map
// used by both the emulator and the scanner's encode path.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] KEY_0    = 8'h00;
    localparam logic [7:0] KEY_1    = 8'h01;
    localparam logic [7:0] KEY_2    = 8'h02;
    localparam logic [7:0] KEY_3    = 8'h03;
    localparam logic [7:0] KEY_4    = 8'h04;
    localparam logic [7:0] KEY_5    = 8'h05;
    localparam logic [7:0] KEY_6    = 8'h06;
    localparam logic [7:0] KEY_7    = 8'h07;
    localparam logic [7:0] KEY_8    = 8'h08;
    localparam logic [7:0] KEY_9    = 8'h09;
    localparam logic [7:0] KEY_STAR = 8'h0A;
    localparam logic [7:0] KEY_HASH = 8'h0B;
    localparam int         KEY_NUM  = 12;

    typedef struct packed {
        logic [1:0] row;   // index of the ROWS bit that selects this key
        logic [2:0] col;   // one-hot column driven onto COLS
    } key_tgt_t;

    typedef struct packed {
        logic     valid;
        key_tgt_t tgt;
    } key_dec_t;

    function automatic key_dec_t key_decode(input logic [7:0] code);
        key_dec_t d;
        d = '0;
        d.valid = 1'b1;
        case (code)
            KEY_1:    d.tgt = '{row: 2'd0, col: 3'b001};
            KEY_2:    d.tgt = '{row: 2'd0, col: 3'b010};
            KEY_3:    d.tgt = '{row: 2'd0, col: 3'b100};
            KEY_4:    d.tgt = '{row: 2'd1, col: 3'b001};
            KEY_5:    d.tgt = '{row: 2'd1, col: 3'b010};
            KEY_6:    d.tgt = '{row: 2'd1, col: 3'b100};
            KEY_7:    d.tgt = '{row: 2'd2, col: 3'b001};
            KEY_8:    d.tgt = '{row: 2'd2, col: 3'b010};
            KEY_9:    d.tgt = '{row: 2'd2, col: 3'b100};
            KEY_STAR: d.tgt = '{row: 2'd3, col: 3'b001};
            KEY_0:    d.tgt = '{row: 2'd3, col: 3'b010};
            KEY_HASH: d.tgt = '{row: 2'd3, col: 3'b100};
            default:  d = '0;
        endcase
        return d;
    endfunction

    // Reverse lookup for the scanner side; 0xFF when the row/column pair is not a key.
    function automatic logic [7:0] key_encode(input key_tgt_t tgt);
        logic [7:0] code;
        key_dec_t   d;
        code = 8'hFF;
        for (int i = 0; i < KEY_NUM; i++) begin
            d = key_decode(8'(i));
            if (d.valid && d.tgt == tgt) code = 8'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_emulator.sv
// Device side of a 3x4 matrix keypad: presses a loaded key for HOLD_CYCLES, then releases for GAP_CYCLES.
// Define KEYPAD_EMU_QUEUE_EN to add a one-entry pending buffer for loads that arrive while busy.
module keypad_emulator #(
    parameter int HOLD_CYCLES = 1000000,
    parameter int GAP_CYCLES  = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] KEY_CODE,
    input  logic       KEY_LOAD,
    input  logic [3:0] ROWS,
    output logic [2:0] COLS,
    output logic       BUSY,
    output logic       DONE,
    output logic       KEY_ERR
);
    import keypad_pkg::*;

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    key_tgt_t         tgt, tgt_nx;
    logic             done_nx, err_nx;
    key_dec_t         dec;

`ifdef KEYPAD_EMU_QUEUE_EN
    logic     pend_vld, pend_vld_nx;
    key_tgt_t pend, pend_nx;
`endif

    assign dec  = key_decode(KEY_CODE);
    assign BUSY = (state != IDLE);

    // Target row is one-hot, so any non-one-hot ROWS pattern can never match.
    assign COLS = (state == PRESS && ROWS == (4'b0001 << tgt.row)) ? tgt.col : 3'b000;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tgt_nx   = tgt;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
`ifdef KEYPAD_EMU_QUEUE_EN
        pend_vld_nx = pend_vld;
        pend_nx     = pend;
`endif
        case (state)
            IDLE: begin
                if (KEY_LOAD) begin
                    if (dec.valid) begin
                        state_nx = PRESS;
                        cnt_nx   = HOLD_LD;
                        tgt_nx   = dec.tgt;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            PRESS: begin
                if (cnt == '0) begin
                    state_nx = GAP;
                    cnt_nx   = GAP_LD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
`ifdef KEYPAD_EMU_QUEUE_EN
        if (BUSY && KEY_LOAD) begin
            if (!dec.valid) begin
                err_nx = 1'b1;
            end else if (!pend_vld) begin
                pend_vld_nx = 1'b1;
                pend_nx     = dec.tgt;
            end
        end
        // A load landing on the last gap cycle chains straight into the next press too.
        if (state == GAP && cnt == '0 && pend_vld_nx) begin
            state_nx    = PRESS;
            cnt_nx      = HOLD_LD;
            tgt_nx      = pend_nx;
            pend_vld_nx = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            tgt     <= '0;
            DONE    <= 1'b0;
            KEY_ERR <= 1'b0;
`ifdef KEYPAD_EMU_QUEUE_EN
            pend_vld <= 1'b0;
            pend     <= '0;
`endif
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            tgt     <= tgt_nx;
            DONE    <= done_nx;
            KEY_ERR <= err_nx;
`ifdef KEYPAD_EMU_QUEUE_EN
            pend_vld <= pend_vld_nx;
            pend     <= pend_nx;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: directed steps plus random traffic, every cycle checked
// against a timeline model of press/gap windows. Honors KEYPAD_EMU_QUEUE_EN like the RTL.
module tb_keypad_emulator;

    localparam int HOLD = 8;
    localparam int GAP  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] KEY_CODE;
    logic       KEY_LOAD;
    logic [3:0] ROWS;
    logic [2:0] COLS;
    logic       BUSY, DONE, KEY_ERR;

    int vecs   = 0;
    int miscmp = 0;
    int cyc    = 0;

    // Model: a press occupies cycles [m_start, m_start+HOLD), gap follows for GAP cycles.
    bit m_act;
    int m_start, m_row, m_col;
    int m_done_cyc, m_err_cyc;
`ifdef KEYPAD_EMU_QUEUE_EN
    bit m_qv;
    int m_qr, m_qc;
`endif

    keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .KEY_CODE(KEY_CODE), .KEY_LOAD(KEY_LOAD),
        .ROWS(ROWS), .COLS(COLS), .BUSY(BUSY), .DONE(DONE), .KEY_ERR(KEY_ERR)
    );

    always #5 clk = ~clk;

    // Keys 1..9 fill rows 0..2 left to right; row 3 is *,0,#.
    function automatic bit m_decode(input int code, output int r, output int c);
        r = 0; c = 0;
        if (code >= 1 && code <= 9) begin r = (code - 1) / 3; c = (code - 1) % 3; return 1; end
        if (code == 10) begin r = 3; c = 0; return 1; end
        if (code == 0)  begin r = 3; c = 1; return 1; end
        if (code == 11) begin r = 3; c = 2; return 1; end
        return 0;
    endfunction

    function automatic bit m_busy();
        return m_act && cyc >= m_start && cyc < m_start + HOLD + GAP;
    endfunction

    function automatic logic [2:0] m_cols(input logic [3:0] rows);
        logic [3:0] sel;
        sel = 4'b0001 << m_row;
        if (m_act && cyc >= m_start && cyc < m_start + HOLD && rows == sel)
            return 3'b001 << m_col;
        return 3'b000;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input logic ld, input logic [7:0] code, input logic rstn);
        bit busy, ok;
        int r, c;
        if (!rstn) begin
            m_act = 0; m_done_cyc = -1; m_err_cyc = -1;
`ifdef KEYPAD_EMU_QUEUE_EN
            m_qv = 0;
`endif
            return;
        end
        busy = m_busy();
        ok   = m_decode(int'(code), r, c);
        if (ld && !busy) begin
            if (ok) begin m_act = 1; m_start = cyc + 1; m_row = r; m_col = c; end
            else m_err_cyc = cyc + 1;
        end
`ifdef KEYPAD_EMU_QUEUE_EN
        if (ld && busy) begin
            if (!ok) m_err_cyc = cyc + 1;
            else if (!m_qv) begin m_qv = 1; m_qr = r; m_qc = c; end
        end
`endif
        if (busy && cyc == m_start + HOLD + GAP - 1) begin
            m_done_cyc = cyc + 1;
            m_act = 0;
`ifdef KEYPAD_EMU_QUEUE_EN
            if (m_qv) begin m_act = 1; m_start = cyc + 1; m_row = m_qr; m_col = m_qc; m_qv = 0; end
`endif
        end
    endtask

    // One clock cycle: drive inputs, check outputs of this cycle, then take the edge.
    task automatic step(input logic ld, input logic [7:0] code, input logic [3:0] rows,
                        input logic rstn, input int xcols);
        logic [2:0] xc;
        rst_n = rstn; KEY_LOAD = ld; KEY_CODE = code; ROWS = rows;
        #2;
        chk("cols",    {5'b0, COLS},    {5'b0, m_cols(rows)});
        chk("busy",    {7'b0, BUSY},    {7'b0, m_busy()});
        chk("done",    {7'b0, DONE},    {7'b0, cyc == m_done_cyc});
        chk("key_err", {7'b0, KEY_ERR}, {7'b0, cyc == m_err_cyc});
        if (xcols >= 0) begin
            xc = 3'(xcols);
            chk("cols_directed", {5'b0, COLS}, {5'b0, xc});
        end
        @(posedge clk);
        model_edge(ld, code, rstn);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n, input logic [3:0] rows, input int xcols);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rows, 1'b1, xcols);
    endtask

    initial begin
        logic [3:0] rows;
        logic [7:0] code;
        rst_n = 1'b0; KEY_LOAD = 1'b0; KEY_CODE = 8'h00; ROWS = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        model_edge(1'b0, 8'h00, 1'b0);

        // reset state, then key 5 on row 1 / column 010
        idle(2, 4'b0010, 0);
        step(1'b1, 8'h05, 4'b0010, 1'b1, 0);
        idle(6, 4'b0010, 3'b010);
        idle(2, 4'b0001, 0);
        idle(6, 4'b0010, 0);

        // key 0 and key # both sit on row 3
        step(1'b1, 8'h00, 4'b1000, 1'b1, -1);
        for (int i = 0; i < 4; i++) begin
            rows = 4'b0001 << i;
            idle(2, rows, (i == 3) ? 3'b010 : 0);
        end
        idle(5, 4'b1000, 0);
        step(1'b1, 8'h0B, 4'b1000, 1'b1, -1);
        for (int i = 0; i < 4; i++) begin
            rows = 4'b0001 << i;
            idle(2, rows, (i == 3) ? 3'b100 : 0);
        end
        idle(5, 4'b1000, 0);

        // invalid code
        step(1'b1, 8'h0C, 4'b0001, 1'b1, 0);
        idle(3, 4'b0001, 0);

        // non-one-hot rows never answer
        step(1'b1, 8'h02, 4'b0011, 1'b1, -1);
        idle(3, 4'b0011, 0);
        idle(2, 4'b0000, 0);
        idle(3, 4'b0001, 3'b010);
        idle(5, 4'b0001, 0);

        // reset in the third press cycle, no DONE afterwards
        step(1'b1, 8'h07, 4'b0100, 1'b1, -1);
        idle(2, 4'b0100, 3'b001);
        step(1'b0, 8'h00, 4'b0100, 1'b0, 3'b001);
        idle(15, 4'b0100, 0);

        // second load while busy: queued or ignored depending on build
        step(1'b1, 8'h01, 4'b0100, 1'b1, -1);
        idle(3, 4'b0100, -1);
        step(1'b1, 8'h09, 4'b0100, 1'b1, -1);
        idle(30, 4'b0100, -1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0) rows = 4'b0001 << $urandom_range(0, 3);
            else rows = 4'($urandom);
            if ($urandom_range(0, 9) == 0) code = 8'($urandom);
            else code = 8'($urandom_range(0, 13));
            step(($urandom_range(0, 5) == 0), code, rows, ($urandom_range(0, 99) != 0), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
